// File: rtl/spi_slave_pkg.sv
// Shared types for the parametrised SPI slave: FSM state encoding and frame command codes.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK_CMD,
        ST_WRITE,
        ST_READ_ADD,
        ST_READ_DATA,
        ST_WAIT_TX,
        ST_SEND
    } state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage : spi_slave_pkg

// File: rtl/spi_shift_reg.sv
// Bidirectional-order shift register with clear, parallel load and serial shift-in.
// next_c is the value the register takes at the coming edge; lead_c is its leading (first-out) bit.
module spi_shift_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic             ser_i,
    output logic [WIDTH-1:0] next_c,
    output logic             lead_c
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] shifted;

    // MSB-first moves data toward the MSB; LSB-first toward the LSB.
    always_comb begin
        shifted = data_q;
        if (MSB_FIRST) begin
            shifted = {data_q[WIDTH-2:0], ser_i};
        end else begin
            shifted = {ser_i, data_q[WIDTH-1:1]};
        end

        next_c = data_q;
        if (clr_i) begin
            next_c = '0;
        end else if (load_i) begin
            next_c = load_data_i;
        end else if (shift_i) begin
            next_c = shifted;
        end

        lead_c = MSB_FIRST ? next_c[WIDTH-1] : next_c[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= next_c;
        end
    end

endmodule : spi_shift_reg

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: deserialises {cmd, payload} frames for the RAM and serialises RAM read data
// onto MISO, with a bounded wait for tx_valid after a read-data frame.
module spi_slave_param
    import spi_slave_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned TX_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              MISO,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data,
    output logic              busy,
    output logic              tx_timeout
);

    localparam int unsigned FRAME_W = DATA_W + 2;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned TMO_W   = $clog2(TX_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] TX_LAST    = CNT_W'(DATA_W - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TX_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               done_q, done_d;
    logic               rd_addr_seen_q, rd_addr_seen_d;
    logic               miso_q, miso_d;
    logic               rx_valid_q, rx_valid_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               busy_q, busy_d;
    logic               tx_timeout_q, tx_timeout_d;

    logic               rx_clr_c, rx_shift_c;
    logic               tx_clr_c, tx_load_c, tx_shift_c;
    logic [FRAME_W-1:0] rx_next_c;
    logic               tx_lead_c;
    logic               rx_lead_unused;
    logic [DATA_W-1:0]  tx_next_unused;

    spi_shift_reg #(
        .WIDTH     (FRAME_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_rx_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (rx_clr_c),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_i     (rx_shift_c),
        .ser_i       (MOSI),
        .next_c      (rx_next_c),
        .lead_c      (rx_lead_unused)
    );

    spi_shift_reg #(
        .WIDTH     (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_tx_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (tx_clr_c),
        .load_i      (tx_load_c),
        .load_data_i (tx_data),
        .shift_i     (tx_shift_c),
        .ser_i       (1'b0),
        .next_c      (tx_next_unused),
        .lead_c      (tx_lead_c)
    );

    // done_q marks a finished frame/transfer: the state is held, idle, until SS_n rises.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        done_d         = done_q;
        rd_addr_seen_d = rd_addr_seen_q;
        miso_d         = 1'b0;
        rx_valid_d     = 1'b0;
        rx_data_d      = rx_data_q;
        tx_timeout_d   = 1'b0;
        rx_clr_c       = 1'b0;
        rx_shift_c     = 1'b0;
        tx_clr_c       = 1'b0;
        tx_load_c      = 1'b0;
        tx_shift_c     = 1'b0;

        if (SS_n) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            tmo_cnt_d = '0;
            done_d    = 1'b0;
            rx_clr_c  = 1'b1;
            tx_clr_c  = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_CHK_CMD;
                end
                ST_CHK_CMD: begin
                    rx_clr_c  = 1'b1;
                    bit_cnt_d = '0;
                    done_d    = 1'b0;
                    if (!MOSI) begin
                        state_d = ST_WRITE;
                    end else if (rd_addr_seen_q) begin
                        state_d = ST_READ_DATA;
                    end else begin
                        state_d = ST_READ_ADD;
                    end
                end
                ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                    if (!done_q) begin
                        rx_shift_c = 1'b1;
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == FRAME_LAST) begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = rx_next_c;
                            bit_cnt_d  = '0;
                            done_d     = 1'b1;
                            if (state_q == ST_READ_ADD) begin
                                rd_addr_seen_d = 1'b1;
                            end
                            if (state_q == ST_READ_DATA) begin
                                rd_addr_seen_d = 1'b0;
                                state_d        = ST_WAIT_TX;
                                tmo_cnt_d      = '0;
                                done_d         = 1'b0;
                            end
                        end
                    end
                end
                ST_WAIT_TX: begin
                    if (!done_q) begin
                        if (tx_valid) begin
                            tx_load_c = 1'b1;
                            miso_d    = tx_lead_c;
                            bit_cnt_d = '0;
                            state_d   = ST_SEND;
                        end else if (tmo_cnt_q == TMO_LAST) begin
                            tx_timeout_d = 1'b1;
                            done_d       = 1'b1;
                        end else begin
                            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                        end
                    end
                end
                ST_SEND: begin
                    // First bit was already driven on the load edge, so DATA_W-1 shifts remain.
                    if (!done_q) begin
                        if (bit_cnt_q == TX_LAST) begin
                            done_d = 1'b1;
                        end else begin
                            tx_shift_c = 1'b1;
                            miso_d     = tx_lead_c;
                            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= '0;
            tmo_cnt_q      <= '0;
            done_q         <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            miso_q         <= 1'b0;
            rx_valid_q     <= 1'b0;
            rx_data_q      <= '0;
            busy_q         <= 1'b0;
            tx_timeout_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            done_q         <= done_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            miso_q         <= miso_d;
            rx_valid_q     <= rx_valid_d;
            rx_data_q      <= rx_data_d;
            busy_q         <= busy_d;
            tx_timeout_q   <= tx_timeout_d;
        end
    end

    assign MISO       = miso_q;
    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign busy       = busy_q;
    assign tx_timeout = tx_timeout_q;

endmodule : spi_slave_param

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: an 8-bit MSB-first instance and a 16-bit LSB-first instance.
module tb_spi_slave_param;
    import spi_slave_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    logic        ss8, mosi8, tv8, miso8, rxv8, busy8, tmo8;
    logic [7:0]  td8;
    logic [9:0]  rxd8;

    logic        ss16, mosi16, tv16, miso16, rxv16, busy16, tmo16;
    logic [15:0] td16;
    logic [17:0] rxd16;

    int total = 0;
    int bad   = 0;

    logic [9:0]  f10;
    logic [17:0] f18;
    logic [7:0]  exp_byte;

    always #5 clk = ~clk;

    spi_slave_param #(
        .DATA_W     (8),
        .MSB_FIRST  (1'b1),
        .TX_TIMEOUT (4)
    ) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .SS_n       (ss8),
        .MOSI       (mosi8),
        .tx_valid   (tv8),
        .tx_data    (td8),
        .MISO       (miso8),
        .rx_valid   (rxv8),
        .rx_data    (rxd8),
        .busy       (busy8),
        .tx_timeout (tmo8)
    );

    spi_slave_param #(
        .DATA_W     (16),
        .MSB_FIRST  (1'b0),
        .TX_TIMEOUT (16)
    ) dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .SS_n       (ss16),
        .MOSI       (mosi16),
        .tx_valid   (tv16),
        .tx_data    (td16),
        .MISO       (miso16),
        .rx_valid   (rxv16),
        .rx_data    (rxd16),
        .busy       (busy16),
        .tx_timeout (tmo16)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start8(input logic cmd);
        ss8 = 1'b0;
        tick();
        mosi8 = cmd;
        tick();
    endtask

    task automatic end8();
        ss8 = 1'b1;
        tick();
    endtask

    task automatic start16(input logic cmd);
        ss16 = 1'b0;
        tick();
        mosi16 = cmd;
        tick();
    endtask

    task automatic end16();
        ss16 = 1'b1;
        tick();
    endtask

    // MSB-first: the first n bits of f, starting at bit 9.
    task automatic shift_in8(input logic [9:0] f, input int n);
        for (int k = 0; k < n; k++) begin
            mosi8 = f[9-k];
            tick();
            if (k != 9) chk("rx8_no_early_valid", 32'(rxv8), 32'd0);
            chk("miso8_quiet_in_frame", 32'(miso8), 32'd0);
        end
    endtask

    // LSB-first: the first n bits of f, starting at bit 0.
    task automatic shift_in16(input logic [17:0] f, input int n);
        for (int k = 0; k < n; k++) begin
            mosi16 = f[k];
            tick();
            if (k != 17) chk("rx16_no_early_valid", 32'(rxv16), 32'd0);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ss8    = 1'b1; mosi8  = 1'b0; tv8  = 1'b0; td8  = '0;
        ss16   = 1'b1; mosi16 = 1'b0; tv16 = 1'b0; td16 = '0;
        tick();
        tick();
        chk("rst_miso8",   32'(miso8), 32'd0);
        chk("rst_rxv8",    32'(rxv8),  32'd0);
        chk("rst_rxd8",    32'(rxd8),  32'd0);
        chk("rst_busy8",   32'(busy8), 32'd0);
        chk("rst_tmo8",    32'(tmo8),  32'd0);
        chk("rst_miso16",  32'(miso16), 32'd0);
        chk("rst_busy16",  32'(busy16), 32'd0);
        chk("rst_rxd16",   32'(rxd16), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy8", 32'(busy8), 32'd0);

        // Write-address frame 00_1010_0101
        start8(1'b0);
        chk("wr_busy8", 32'(busy8), 32'd1);
        f10 = {CMD_WR_ADDR, 8'hA5};
        shift_in8(f10, 10);
        chk("wr_rxv8",  32'(rxv8),  32'd1);
        chk("wr_rxd8",  32'(rxd8),  32'h0A5);
        chk("wr_miso8", 32'(miso8), 32'd0);
        mosi8 = 1'b1; tv8 = 1'b1; td8 = 8'hFF;
        tick();
        chk("wr_rxv8_pulse", 32'(rxv8),  32'd0);
        chk("wr_tv_ignored", 32'(miso8), 32'd0);
        tick();
        chk("wr_extra_bits_ignored", 32'(rxv8), 32'd0);
        chk("wr_rxd8_held", 32'(rxd8), 32'h0A5);
        tv8 = 1'b0;
        end8();
        chk("wr_end_busy8", 32'(busy8), 32'd0);

        // Read address (first read after reset) then read data with tx_valid two cycles later
        start8(1'b1);
        f10 = {CMD_RD_ADDR, 8'h03};
        shift_in8(f10, 10);
        chk("ra_rxv8", 32'(rxv8), 32'd1);
        chk("ra_rxd8", 32'(rxd8), 32'h203);
        end8();
        start8(1'b1);
        f10 = {CMD_RD_DATA, 8'h00};
        shift_in8(f10, 10);
        chk("rd_rxv8", 32'(rxv8), 32'd1);
        chk("rd_rxd8", 32'(rxd8), 32'h300);
        tick();
        chk("rd_wait_miso8", 32'(miso8), 32'd0);
        tv8 = 1'b1; td8 = 8'hC3;
        tick();
        tv8 = 1'b0; td8 = 8'h00;
        exp_byte = 8'hC3;
        for (int i = 7; i >= 0; i--) begin
            chk("rd_miso8_bit", 32'(miso8), 32'(exp_byte[i]));
            tick();
        end
        chk("rd_miso8_after", 32'(miso8), 32'd0);
        chk("rd_busy8_after", 32'(busy8), 32'd1);
        chk("rd_no_tmo8",     32'(tmo8),  32'd0);
        end8();
        chk("rd_end_busy8", 32'(busy8), 32'd0);

        // Timeout: tx_valid withheld after a read-data frame
        start8(1'b1);
        f10 = {CMD_RD_ADDR, 8'h5A};
        shift_in8(f10, 10);
        end8();
        start8(1'b1);
        f10 = {CMD_RD_DATA, 8'h55};
        shift_in8(f10, 10);
        chk("to_rxd8", 32'(rxd8), 32'h355);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("to_tmo8_timing", 32'(tmo8), 32'(i == 4));
            chk("to_miso8",       32'(miso8), 32'd0);
        end
        tv8 = 1'b1; td8 = 8'hFF;
        tick();
        chk("to_tmo8_once", 32'(tmo8),  32'd0);
        chk("to_late_tv",   32'(miso8), 32'd0);
        tick();
        chk("to_late_tv2",  32'(miso8), 32'd0);
        chk("to_busy8",     32'(busy8), 32'd1);
        tv8 = 1'b0;
        end8();

        // Abort after 5 bits, then a clean write-data frame
        start8(1'b0);
        f10 = {CMD_WR_DATA, 8'h5A};
        shift_in8(f10, 5);
        ss8 = 1'b1;
        tick();
        chk("ab_rxv8",  32'(rxv8),  32'd0);
        chk("ab_busy8", 32'(busy8), 32'd0);
        chk("ab_rxd8",  32'(rxd8),  32'h355);
        start8(1'b0);
        shift_in8(f10, 10);
        chk("ab_next_rxv8", 32'(rxv8), 32'd1);
        chk("ab_next_rxd8", 32'(rxd8), 32'h15A);
        end8();

        // SS_n rising on the frame's final bit discards the frame
        start8(1'b0);
        f10 = {CMD_WR_ADDR, 8'h3C};
        shift_in8(f10, 9);
        mosi8 = f10[0];
        ss8 = 1'b1;
        tick();
        chk("ssprio_rxv8",  32'(rxv8),  32'd0);
        chk("ssprio_rxd8",  32'(rxd8),  32'h15A);
        chk("ssprio_busy8", 32'(busy8), 32'd0);

        // 16-bit LSB-first write
        start16(1'b0);
        f18 = {CMD_WR_DATA, 16'hABCD};
        shift_in16(f18, 18);
        chk("lsb_rxv16", 32'(rxv16), 32'd1);
        chk("lsb_rxd16", 32'(rxd16), 32'h1ABCD);
        end16();

        // 16-bit read, then async reset in the middle of SEND
        start16(1'b1);
        f18 = {CMD_RD_ADDR, 16'h0000};
        shift_in16(f18, 18);
        end16();
        start16(1'b1);
        f18 = {CMD_RD_DATA, 16'h0000};
        shift_in16(f18, 18);
        chk("lsb_rd_rxd16", 32'(rxd16), 32'h30000);
        tv16 = 1'b1; td16 = 16'h0005;
        tick();
        tv16 = 1'b0; td16 = '0;
        chk("lsb_miso16_b0", 32'(miso16), 32'd1);
        tick();
        chk("lsb_miso16_b1", 32'(miso16), 32'd0);
        tick();
        chk("lsb_miso16_b2", 32'(miso16), 32'd1);
        chk("lsb_busy16",    32'(busy16), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_miso16", 32'(miso16), 32'd0);
        chk("arst_busy16", 32'(busy16), 32'd0);
        chk("arst_rxd16",  32'(rxd16),  32'd0);
        @(negedge clk);
        ss16 = 1'b1;
        rst_n = 1'b1;
        tick();

        // Reset clears rd_addr_seen: a read command goes to READ_ADD, so tx_valid has no effect
        start16(1'b1);
        f18 = {CMD_RD_ADDR, 16'h1234};
        shift_in16(f18, 18);
        chk("post_rst_rxv16", 32'(rxv16), 32'd1);
        chk("post_rst_rxd16", 32'(rxd16), 32'h21234);
        tv16 = 1'b1; td16 = 16'hFFFF;
        tick();
        tick();
        chk("post_rst_readadd_miso16", 32'(miso16), 32'd0);
        chk("post_rst_busy16",         32'(busy16), 32'd1);
        tv16 = 1'b0;
        end16();
        chk("post_rst_end_busy16", 32'(busy16), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_spi_slave_param
